alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single combinational ALU (8-bit signed A/B, 4-bit `sel`, 8-bit `Y`, 2-bit `flag`) between two requesters. Each requester has a valid/ready request channel, and all results return on one shared valid/ready response channel. Arbitration is round-robin. Each operation runs a fixed three-state sequence: accept, execute, respond. The block sits between the two operand sources and the ALU instance; the ALU itself is external.

## Interface
Parameters:
- `W`, 8, operand/result width
- `SEL_W`, 4, opcode width
- `MAX_OP`, 8, highest legal opcode; opcodes above it return an error
- `CNT_W`, 16, width of the completed-operation counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  signed operands
- `req0_sel` / `req1_sel`  in  SEL_W  opcode
- `alu_a`, `alu_b`  out  W  ALU operands
- `alu_sel`  out  SEL_W  ALU opcode
- `alu_y`  in  W  ALU result
- `alu_flag`  in  2  ALU flags
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  1  requester index of the response
- `rsp_y`  out  W  result
- `rsp_flag`  out  2  flags
- `rsp_err`  out  1  opcode exceeded MAX_OP
- `busy`  out  1  state != IDLE
- `op_cnt`  out  CNT_W  completed responses; wraps to 0 after all-ones

## Operation
- FSM states are IDLE, EXEC and RESP. The state register is the only control state besides `last_grant`.
- Arbitration in IDLE:
  - If only one requester is valid, it is granted.
  - If both are valid, the grant goes to the index != `last_grant`.
  - If neither is valid, no grant.
  - `reqN_ready` = (state==IDLE) && grant==N. This is combinational from the valids, and at most one ready is high.
- On handshake in IDLE:
  - Latch a, b, sel and the granted id into operand registers.
  - Set `last_grant` to the granted id.
  - Go to EXEC.
- EXEC (exactly one cycle):
  - `alu_a`/`alu_b`/`alu_sel` carry the latched values. They are registered outputs and hold their last value in every state.
  - At the end of the cycle, capture `alu_y` and `alu_flag` into the response registers.
  - If the latched sel > MAX_OP: `rsp_y`=0, `rsp_flag`=0, `rsp_err`=1. Otherwise `rsp_err`=0.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_id`/`rsp_y`/`rsp_flag`/`rsp_err` are stable until the handshake.
  - On `rsp_ready`: `op_cnt` += 1, go to IDLE.
- No new request is accepted outside IDLE, so requester ready stays low during EXEC and RESP.
- Width rules: results pass through unmodified, with no sign extension or truncation. `op_cnt` is modulo 2^CNT_W.
- Reset values:
  - state IDLE, `last_grant`=1 (requester 0 wins the first tie)
  - `alu_a`=`alu_b`=0, `alu_sel`=0
  - `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_flag`=0, `rsp_err`=0
  - `busy`=0, `op_cnt`=0
- Reset asserted mid-operation (EXEC or RESP):
  - Immediate return to IDLE.
  - The pending response is discarded and `rsp_valid` drops asynchronously.
  - `op_cnt` is cleared.

## Timing
- Request handshake at edge N. EXEC is cycle N..N+1, and `alu_*` update at edge N. The response is captured at edge N+1, and `rsp_valid` is high from edge N+1.
- Latency from request accept to `rsp_valid` is 1 cycle. Minimum period per operation is 3 cycles (IDLE, EXEC, RESP) when `rsp_ready` is held high.
- Backpressure: RESP holds indefinitely while `rsp_ready`=0. Outputs must not change during the stall.
- `rsp_ready` high outside RESP is ignored.
- A requester that drops valid before ready loses nothing. Arbitration is re-evaluated each IDLE cycle.
- The ALU is sampled only in EXEC. The ALU path from `alu_*` to `alu_y` must close within one cycle.

## Test plan
- Single request: req0 a=8'h0C, b=8'h09, sel=0, with the bench ALU model driving `alu_y`=8'h15, flag=2'b00 -> `req0_ready` high in IDLE; `alu_a`=0C, `alu_b`=09, `alu_sel`=0 one edge later; `rsp_valid` one edge after that with id=0, y=15, err=0; `op_cnt`=1.
- Contention: both valid from reset, each with 3 ops, `rsp_ready`=1 -> grant order 0,1,0,1,0,1; `op_cnt`=6; one response every 3 cycles.
- Backpressure: `rsp_ready`=0 for 10 cycles in RESP -> `rsp_*` stable and both readys low throughout. After release: one response, then IDLE.
- Illegal opcode: req1 sel=4'hF -> `rsp_id`=1, `rsp_err`=1, `rsp_y`=0, `rsp_flag`=0; `op_cnt` increments.
- Async reset in RESP: assert `rst_n`=0 mid-cycle -> `rsp_valid` and `busy` drop without waiting for clk. After release: `op_cnt`=0, and req0 wins the next tie.
- Counter wrap: preload via CNT_W=4 build, 17 ops -> `op_cnt` reads 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between two
// valid/ready requesters, with a single shared response channel.
module alu_arbiter #(
  parameter int W      = 8,
  parameter int SEL_W  = 4,
  parameter int MAX_OP = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_y,
  input  logic [1:0]       alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic [1:0]       rsp_flag,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int unsigned MAX_SEL = MAX_OP;

  state_t state;
  logic   last_grant;
  logic   op_id;
  logic   grant_valid;
  logic   grant_id;
  logic   sel_illegal;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  assign req0_ready  = (state == IDLE) && grant_valid && !grant_id;
  assign req1_ready  = (state == IDLE) && grant_valid &&  grant_id;
  assign busy        = (state != IDLE);
  assign sel_illegal = 32'(alu_sel) > MAX_SEL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_flag   <= '0;
      rsp_err    <= 1'b0;
      op_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_a      <= grant_id ? req1_a   : req0_a;
            alu_b      <= grant_id ? req1_b   : req0_b;
            alu_sel    <= grant_id ? req1_sel : req0_sel;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
          if (sel_illegal) begin
            rsp_y    <= '0;
            rsp_flag <= '0;
            rsp_err  <= 1'b1;
          end else begin
            rsp_y    <= alu_y;
            rsp_flag <= alu_flag;
            rsp_err  <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_cnt    <= op_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_alu_arbiter;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } op_t;

  typedef struct packed {
    logic       id;
    logic [7:0] y;
    logic [1:0] flag;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_sel;
  logic [1:0] alu_flag;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_y;
  logic [1:0] rsp_flag;
  logic [15:0] op_cnt;

  logic       d4_req0_ready, d4_req1_ready;
  logic [7:0] d4_alu_a, d4_alu_b, d4_alu_y;
  logic [3:0] d4_alu_sel;
  logic [1:0] d4_alu_flag;
  logic       d4_rsp_valid, d4_rsp_id, d4_rsp_err, d4_busy;
  logic [7:0] d4_rsp_y;
  logic [1:0] d4_rsp_flag;
  logic [3:0] d4_op_cnt;

  int checks   = 0;
  int failures = 0;
  logic m_last = 1'b1;
  int   m_cnt  = 0;

  // Behavioural ALU standing in for the external instance: {flag, y}.
  function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    logic [7:0] y;
    case (sel)
      4'd0: y = a + b;
      4'd1: y = a - b;
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = a << 1;
      4'd6: y = a >> 1;
      4'd7: y = $unsigned($signed(a) >>> 1);
      4'd8: y = ~a;
      default: y = a + 8'h5A;
    endcase
    return {(y == 8'h00), y[7], y};
  endfunction

  function automatic exp_t model_rsp(input logic id, input op_t op);
    exp_t e;
    logic [9:0] r;
    r = alu_fn(op.a, op.b, op.sel);
    e.id = id;
    if (op.sel > 4'd8) begin
      e.y = '0; e.flag = '0; e.err = 1'b1;
    end else begin
      e.y = r[7:0]; e.flag = r[9:8]; e.err = 1'b0;
    end
    return e;
  endfunction

  assign {alu_flag, alu_y}       = alu_fn(alu_a, alu_b, alu_sel);
  assign {d4_alu_flag, d4_alu_y} = alu_fn(d4_alu_a, d4_alu_b, d4_alu_sel);

  alu_arbiter #(.W(8), .SEL_W(4), .MAX_OP(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy), .op_cnt(op_cnt)
  );

  alu_arbiter #(.W(8), .SEL_W(4), .MAX_OP(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(d4_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(d4_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel), .alu_y(d4_alu_y), .alu_flag(d4_alu_flag),
    .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d4_rsp_id), .rsp_y(d4_rsp_y),
    .rsp_flag(d4_rsp_flag), .rsp_err(d4_rsp_err), .busy(d4_busy), .op_cnt(d4_op_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_sel = '0; req1_a = '0; req1_b = '0; req1_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    m_cnt  = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    #3;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, busy} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got %b want 0000", {rsp_valid, rsp_id, rsp_err, busy});
    end
    checks++;
    if ({rsp_y, rsp_flag} !== 10'h000) begin
      failures++; $display("FAIL reset_rsp_data: got %h want 000", {rsp_y, rsp_flag});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== 20'h00000) begin
      failures++; $display("FAIL reset_alu: got %h want 00000", {alu_a, alu_b, alu_sel});
    end
    checks++;
    if (op_cnt !== 16'd0 || d4_op_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_op_cnt: got %0d/%0d want 0/0", op_cnt, d4_op_cnt);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1; m_cnt = 0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h09; req0_sel = 4'd0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_sel, rsp_valid, busy} !== {8'h0C, 8'h09, 4'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL single_exec: got a=%h b=%h sel=%h rv=%b busy=%b want a=0c b=09 sel=0 rv=0 busy=1",
                           alu_a, alu_b, alu_sel, rsp_valid, busy);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err} !== {1'b1, 1'b0, 8'h15, 2'b00, 1'b0}) begin
      failures++; $display("FAIL single_rsp: got v=%b id=%b y=%h f=%b e=%b want v=1 id=0 y=15 f=00 e=0",
                           rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_cnt++; m_last = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b00 || op_cnt !== 16'(m_cnt)) begin
      failures++; $display("FAIL single_done: got v=%b busy=%b cnt=%0d want v=0 busy=0 cnt=%0d",
                           rsp_valid, busy, op_cnt, m_cnt);
    end
  endtask

  task automatic test_illegal();
    req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 4'hF;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL illegal_ready: got %b want 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err} !== {1'b1, 1'b1, 8'h00, 2'b00, 1'b1}) begin
      failures++; $display("FAIL illegal_rsp: got v=%b id=%b y=%h f=%b e=%b want v=1 id=1 y=00 f=00 e=1",
                           rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_cnt++; m_last = 1'b1;
    checks++;
    if (op_cnt !== 16'(m_cnt)) begin
      failures++; $display("FAIL illegal_cnt: got %0d want %0d", op_cnt, m_cnt);
    end
  endtask

  task automatic test_backpressure();
    op_t  op;
    exp_t e;
    op.a = 8'($urandom); op.b = 8'($urandom); op.sel = 4'($urandom_range(0, 8));
    e = model_rsp(1'b1, op);
    req1_valid = 1'b1; req1_a = op.a; req1_b = op.b; req1_sel = op.sel; rsp_ready = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_accept: got %b want 01", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b1;
    req1_sel = 4'($urandom);
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b001) begin
      failures++; $display("FAIL bp_exec_ready: got %b want 001", {req0_ready, req1_ready, busy});
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err, req0_ready, req1_ready} !==
          {1'b1, e.id, e.y, e.flag, e.err, 2'b00}) begin
        failures++; $display("FAIL bp_stall[%0d]: got v=%b id=%b y=%h f=%b e=%b rdy=%b%b want v=1 id=%b y=%h f=%b e=%b rdy=00",
                             i, rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err, req0_ready, req1_ready,
                             e.id, e.y, e.flag, e.err);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    m_cnt++; m_last = 1'b1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00 || op_cnt !== 16'(m_cnt)) begin
      failures++; $display("FAIL bp_release: got v=%b busy=%b cnt=%0d want v=0 busy=0 cnt=%0d",
                           rsp_valid, busy, op_cnt, m_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        failures++; $display("FAIL bp_idle[%0d]: got v=%b busy=%b want 0 0", i, rsp_valid, busy);
      end
    end
    rsp_ready = 1'b0;
  endtask

  // Randomized traffic against a transaction-level model; starts and ends at posedge+1.
  task automatic traffic(input int n0, input int n1, input int vpct, input int rpct, input bit chk_period);
    op_t  q0[$], q1[$];
    exp_t eq[$];
    op_t  cur;
    exp_t f;
    bit   idle = 1'b1, v0, v1, e0, e1, rsp_hs;
    int   got = 0, last_rsp = -1, acc_cyc = 0, cyc;
    for (int i = 0; i < n0; i++) q0.push_back('{a: 8'($urandom), b: 8'($urandom), sel: 4'($urandom)});
    for (int i = 0; i < n1; i++) q1.push_back('{a: 8'($urandom), b: 8'($urandom), sel: 4'($urandom)});
    cur = '0;
    for (cyc = 0; cyc < 3000 && got < n0 + n1; cyc++) begin
      v0 = (q0.size() > 0) && ($urandom_range(0, 99) < vpct);
      v1 = (q1.size() > 0) && ($urandom_range(0, 99) < vpct);
      req0_valid = v0; req1_valid = v1;
      if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_sel = q0[0].sel; end
      if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_sel = q1[0].sel; end
      rsp_ready = ($urandom_range(0, 99) < rpct);
      #1;
      e0 = idle && v0 && (!v1 || m_last == 1'b1);
      e1 = idle && v1 && (!v0 || m_last == 1'b0);
      checks++;
      if ({req0_ready, req1_ready, d4_req0_ready, d4_req1_ready} !== {e0, e1, e0, e1}) begin
        failures++; $display("FAIL tr_ready c%0d: got %b%b/%b%b want %b%b", cyc,
                             req0_ready, req1_ready, d4_req0_ready, d4_req1_ready, e0, e1);
      end
      checks++;
      if ({busy, d4_busy} !== {!idle, !idle} || op_cnt !== 16'(m_cnt) || d4_op_cnt !== 4'(m_cnt)) begin
        failures++; $display("FAIL tr_state c%0d: got busy=%b/%b cnt=%0d/%0d want busy=%b cnt=%0d/%0d", cyc,
                             busy, d4_busy, op_cnt, d4_op_cnt, !idle, 16'(m_cnt), 4'(m_cnt));
      end
      if (!idle && cyc >= acc_cyc + 1) begin
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {cur.a, cur.b, cur.sel}) begin
          failures++; $display("FAIL tr_alu c%0d: got %h %h %h want %h %h %h", cyc,
                               alu_a, alu_b, alu_sel, cur.a, cur.b, cur.sel);
        end
      end
      rsp_hs = 1'b0;
      if (!idle) begin
        checks++;
        if (rsp_valid !== (cyc >= acc_cyc + 2) || d4_rsp_valid !== (cyc >= acc_cyc + 2)) begin
          failures++; $display("FAIL tr_rsp_valid c%0d: got %b/%b want %b", cyc, rsp_valid, d4_rsp_valid,
                               (cyc >= acc_cyc + 2));
        end
        if (cyc >= acc_cyc + 2) begin
          f = eq[0];
          checks++;
          if ({rsp_id, rsp_y, rsp_flag, rsp_err, d4_rsp_id, d4_rsp_y, d4_rsp_flag, d4_rsp_err} !==
              {f.id, f.y, f.flag, f.err, f.id, f.y, f.flag, f.err}) begin
            failures++; $display("FAIL tr_rsp c%0d: got id=%b y=%h f=%b e=%b (d4 id=%b y=%h f=%b e=%b) want id=%b y=%h f=%b e=%b",
                                 cyc, rsp_id, rsp_y, rsp_flag, rsp_err, d4_rsp_id, d4_rsp_y, d4_rsp_flag,
                                 d4_rsp_err, f.id, f.y, f.flag, f.err);
          end
          if (rsp_ready) begin
            rsp_hs = 1'b1;
            void'(eq.pop_front());
            got++;
            m_cnt++;
            if (chk_period && last_rsp >= 0) begin
              checks++;
              if (cyc - last_rsp != 3) begin
                failures++; $display("FAIL tr_period: got %0d cycles want 3", cyc - last_rsp);
              end
            end
            last_rsp = cyc;
          end
        end
      end
      if (e0 || e1) begin
        cur = e0 ? q0.pop_front() : q1.pop_front();
        eq.push_back(model_rsp(e1, cur));
        m_last  = e1;
        idle    = 1'b0;
        acc_cyc = cyc;
      end
      tick();
      if (rsp_hs) idle = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (got != n0 + n1) begin
      failures++; $display("FAIL tr_timeout: got %0d responses want %0d", got, n0 + n1);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    traffic(3, 3, 100, 100, 1'b1);
    checks++;
    if (op_cnt !== 16'd6) begin
      failures++; $display("FAIL contention_cnt: got %0d want 6", op_cnt);
    end
  endtask

  task automatic test_random();
    traffic(8, 8, 60, 50, 1'b0);
    traffic(5, 0, 40, 30, 1'b0);
  endtask

  task automatic test_async_reset();
    req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 4'($urandom_range(0, 8));
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, busy} !== 2'b11) begin
      failures++; $display("FAIL ar_pre: got v=%b busy=%b want 1 1", rsp_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, d4_rsp_valid, d4_busy} !== 4'b0000 || op_cnt !== 16'd0) begin
      failures++; $display("FAIL ar_async: got v=%b busy=%b cnt=%0d want v=0 busy=0 cnt=0",
                           rsp_valid, busy, op_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1; m_cnt = 0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h33; req0_b = 8'h11; req0_sel = 4'd1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL ar_tie: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, 1'b0, 8'h22, 1'b0}) begin
      failures++; $display("FAIL ar_rsp: got v=%b id=%b y=%h e=%b want v=1 id=0 y=22 e=0",
                           rsp_valid, rsp_id, rsp_y, rsp_err);
    end
    tick();
    rsp_ready = 1'b0;
    m_cnt = 1; m_last = 1'b0;
    checks++;
    if (op_cnt !== 16'd1) begin
      failures++; $display("FAIL ar_cnt: got %0d want 1", op_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    traffic(9, 8, 100, 100, 1'b1);
    checks++;
    if (op_cnt !== 16'd17 || d4_op_cnt !== 4'd1) begin
      failures++; $display("FAIL wrap_cnt: got %0d/%0d want 17/1", op_cnt, d4_op_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_illegal();
    test_backpressure();
    test_contention();
    test_random();
    test_async_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
